vram_access_arbiter: RTL and testbench

//  Shares the single-port VRAM between the external-bus data-port engine (port 0, CPU)
//  and three display fetchers (ports 1-3: layer0, layer1, sprite). One access per clk25

---
 rtl/vram_access_arbiter.sv | 108 ++++++++++
 tb/tb_vram_access_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_access_arbiter.sv
// rtl/vram_access_arbiter.sv - single-port VRAM arbiter: CPU port plus three round-robin display ports
module vram_access_arbiter #(
  parameter int ADDR_W       = 17,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk25,
  input  logic                  rst,
  input  logic [3:0]            req,
  input  logic [4*ADDR_W-1:0]   req_addr,
  input  logic                  cpu_we,
  input  logic [DATA_W-1:0]     cpu_wrdata,
  output logic [3:0]            ack,
  output logic [3:0]            rd_valid,
  output logic [DATA_W-1:0]     rd_data,
  output logic [ADDR_W-1:0]     vram_addr,
  output logic [DATA_W-1:0]     vram_wrdata,
  output logic                  vram_wren,
  output logic                  vram_rden,
  input  logic [DATA_W-1:0]     vram_rddata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]        wait_cnt [1:3];
  logic [1:0]        rr_ptr;
  logic [3:0]        urgent;
  logic [3:0]        disp_req;
  logic [3:0]        grant;
  logic [3:0]        rd_tag;
  logic              cpu_write;
  logic [ADDR_W-1:0] grant_addr;

  // Pick the first set bit of mask[3:1], searching from ptr+1 and wrapping 3 -> 1.
  function automatic logic [3:0] rr_pick(input logic [3:0] mask, input logic [1:0] ptr);
    logic [1:0] p;
    rr_pick = '0;
    p = ptr;
    for (int k = 0; k < 3; k++) begin
      p = (p == 2'd3) ? 2'd1 : p + 2'd1;
      if (mask[p] && rr_pick == 4'd0) rr_pick[p] = 1'b1;
    end
  endfunction

  // Grant decision: urgent display ports, then CPU, then any display port.
  always_comb begin
    urgent   = '0;
    disp_req = '0;
    grant    = '0;
    for (int i = 1; i <= 3; i++) begin
      disp_req[i] = req[i];
      urgent[i]   = req[i] && (wait_cnt[i] == LIMIT);
    end
    if (rst)            grant = '0;
    else if (|urgent)   grant = rr_pick(urgent, rr_ptr);
    else if (req[0])    grant = 4'b0001;
    else                grant = rr_pick(disp_req, rr_ptr);
  end

  assign ack       = grant;
  assign cpu_write = grant[0] & cpu_we;

  // Address of the granted port for the VRAM address register.
  always_comb begin
    grant_addr = '0;
    for (int i = 0; i < 4; i++) begin
      if (grant[i]) grant_addr = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Starvation counters and round-robin pointer.
  always_ff @(posedge clk25) begin
    if (rst) begin
      for (int i = 1; i <= 3; i++) wait_cnt[i] <= '0;
      rr_ptr <= 2'd3;
    end else begin
      for (int i = 1; i <= 3; i++) begin
        if (!req[i] || grant[i])     wait_cnt[i] <= '0;
        else if (wait_cnt[i] != LIMIT) wait_cnt[i] <= wait_cnt[i] + 4'd1;
      end
      if (grant[1])      rr_ptr <= 2'd1;
      else if (grant[2]) rr_ptr <= 2'd2;
      else if (grant[3]) rr_ptr <= 2'd3;
    end
  end

  // VRAM command stage and two-deep read tag pipeline; reset drops in-flight reads.
  always_ff @(posedge clk25) begin
    if (rst) begin
      vram_addr   <= '0;
      vram_wrdata <= '0;
      vram_wren   <= 1'b0;
      vram_rden   <= 1'b0;
      rd_tag      <= '0;
      rd_valid    <= '0;
    end else begin
      vram_wren <= cpu_write;
      vram_rden <= (|grant) && !cpu_write;
      rd_tag    <= cpu_write ? 4'd0 : grant;
      rd_valid  <= rd_tag;
      if (|grant)    vram_addr   <= grant_addr;
      if (cpu_write) vram_wrdata <= cpu_wrdata;
    end
  end

  assign rd_data = (|rd_valid) ? vram_rddata : '0;

endmodule

// File: tb/tb_vram_access_arbiter.sv
// tb/tb_vram_access_arbiter.sv - scoreboard bench for vram_access_arbiter
module tb_vram_access_arbiter;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 8;
  localparam int LIMIT  = 4;

  logic                clk25 = 1'b0;
  logic                rst;
  logic [3:0]          req;
  logic [ADDR_W-1:0]   a [0:3];
  logic [4*ADDR_W-1:0] req_addr;
  logic                cpu_we;
  logic [DATA_W-1:0]   cpu_wrdata;
  logic [3:0]          ack;
  logic [3:0]          rd_valid;
  logic [DATA_W-1:0]   rd_data;
  logic [ADDR_W-1:0]   vram_addr;
  logic [DATA_W-1:0]   vram_wrdata;
  logic                vram_wren;
  logic                vram_rden;
  logic [DATA_W-1:0]   vram_rddata;

  assign req_addr = {a[3], a[2], a[1], a[0]};

  vram_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk25(clk25), .rst(rst), .req(req), .req_addr(req_addr), .cpu_we(cpu_we),
    .cpu_wrdata(cpu_wrdata), .ack(ack), .rd_valid(rd_valid), .rd_data(rd_data),
    .vram_addr(vram_addr), .vram_wrdata(vram_wrdata), .vram_wren(vram_wren),
    .vram_rden(vram_rden), .vram_rddata(vram_rddata)
  );

  always #5 clk25 = ~clk25;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] seed_byte(input logic [ADDR_W-1:0] ad);
    return ad[7:0] ^ {ad[16:13], ad[12:9]} ^ 8'h3C;
  endfunction

  // synchronous VRAM model: data valid the cycle after rden
  logic [7:0] ram     [0:(1<<ADDR_W)-1];
  bit         written [0:(1<<ADDR_W)-1];
  always @(posedge clk25) begin
    if (vram_wren) begin
      ram[vram_addr]     <= vram_wrdata;
      written[vram_addr] <= 1'b1;
    end
    if (vram_rden) vram_rddata <= written[vram_addr] ? ram[vram_addr] : seed_byte(vram_addr);
  end

  // reference model state
  logic [7:0] shadow [int];
  logic [3:0] m_wait [1:3] = '{4'd0, 4'd0, 4'd0};
  int         m_rr = 3;
  logic       m_wren = 1'b0, m_rden = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [7:0] m_wrdata = '0;
  typedef struct { int port; logic [7:0] data; int due; } rd_t;
  rd_t        sb [$];
  int         cyc = 0;
  logic [3:0] last_ack = '0;
  logic [3:0] log_q [$];
  logic [3:0] auto_mask = '0;
  logic [7:0] last_rd [0:3];
  int         wt [1:3] = '{0, 0, 0};
  int         maxw = 0;

  function automatic logic [7:0] shadow_rd(input logic [ADDR_W-1:0] ad);
    return shadow.exists(int'(ad)) ? shadow[int'(ad)] : seed_byte(ad);
  endfunction

  function automatic logic [3:0] model_grant();
    int p;
    logic [3:0] g;
    g = '0;
    for (int k = 1; k <= 3; k++) begin
      p = (m_rr + k - 1) % 3 + 1;
      if (g == 4'd0 && req[p] && m_wait[p] == 4'(LIMIT)) g[p] = 1'b1;
    end
    if (g == 4'd0 && req[0]) g = 4'b0001;
    for (int k = 1; k <= 3; k++) begin
      p = (m_rr + k - 1) % 3 + 1;
      if (g == 4'd0 && req[p]) g[p] = 1'b1;
    end
    return g;
  endfunction

  // one clock: check outputs, advance the model, clock, update requesters
  task automatic step();
    logic [3:0] eg;
    int idx;
    #1;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      check_eq("rd_valid", rd_valid, 32'(4'b0001 << sb[0].port));
      check_eq("rd_data", rd_data, sb[0].data);
      last_rd[sb[0].port] = rd_data;
      void'(sb.pop_front());
    end else begin
      check_eq("rd_valid_idle", rd_valid, 0);
    end
    check_eq("vram_wren", vram_wren, m_wren);
    check_eq("vram_rden", vram_rden, m_rden);
    if (m_wren || m_rden) check_eq("vram_addr", vram_addr, m_addr);
    if (m_wren) check_eq("vram_wrdata", vram_wrdata, m_wrdata);
    eg = rst ? 4'd0 : model_grant();
    check_eq("ack", ack, eg);
    last_ack = ack;
    if (rst) begin
      for (int i = 1; i <= 3; i++) m_wait[i] = '0;
      m_rr = 3; m_wren = 1'b0; m_rden = 1'b0;
      sb.delete();
    end else begin
      log_q.push_back(ack);
      for (int i = 1; i <= 3; i++) begin
        if (req[i] && !ack[i]) wt[i]++; else wt[i] = 0;
        if (wt[i] > maxw) maxw = wt[i];
        if (!req[i] || eg[i]) m_wait[i] = '0;
        else if (m_wait[i] != 4'(LIMIT)) m_wait[i] = m_wait[i] + 4'd1;
        if (eg[i]) m_rr = i;
      end
      idx = 0;
      for (int i = 0; i < 4; i++) if (eg[i]) idx = i;
      m_wren = eg[0] && cpu_we;
      m_rden = (eg != 4'd0) && !m_wren;
      if (eg != 4'd0) m_addr = a[idx];
      if (m_wren) begin
        m_wrdata = cpu_wrdata;
        shadow[int'(m_addr)] = cpu_wrdata;
      end else if (m_rden) begin
        sb.push_back('{idx, shadow_rd(m_addr), cyc + 2});
      end
    end
    @(posedge clk25);
    cyc++;
    @(negedge clk25);
    for (int i = 0; i < 4; i++) begin
      if (last_ack[i]) begin
        if (auto_mask[i]) a[i] = 17'($urandom_range(0, 255));
        else req[i] = 1'b0;
      end
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1; req = '0; auto_mask = '0;
    step();
    rst = 1'b0;
    log_q.delete();
    for (int i = 1; i <= 3; i++) wt[i] = 0;
  endtask

  logic [3:0] exp_rr [0:5]   = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000};
  logic [3:0] exp_st [0:7]   = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                                 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    rst = 1'b1; req = '0; cpu_we = 1'b0; cpu_wrdata = '0;
    for (int i = 0; i < 4; i++) begin a[i] = '0; last_rd[i] = '0; end
    @(negedge clk25);
    step(); step();
    check_eq("reset_vram_addr", vram_addr, 0);
    check_eq("reset_vram_wrdata", vram_wrdata, 0);
    check_eq("reset_rd_data", rd_data, 0);
    rst = 1'b0;

    // single display read
    req = 4'b0100; a[2] = 17'h1ABCD;
    step();
    check_eq("t1_ack", last_ack, 4'b0100);
    check_eq("t1_addr", vram_addr, 17'h1ABCD);
    check_eq("t1_rden", vram_rden, 1);
    step();
    check_eq("t1_rd_valid", rd_valid, 4'b0100);
    check_eq("t1_rd_data", rd_data, seed_byte(17'h1ABCD));
    step();

    // CPU write, then read back through port 1
    req = 4'b0001; cpu_we = 1'b1; a[0] = 17'h00010; cpu_wrdata = 8'h5A;
    step();
    check_eq("t2_wren", vram_wren, 1);
    check_eq("t2_wrdata", vram_wrdata, 8'h5A);
    cpu_we = 1'b0;
    req = 4'b0010; a[1] = 17'h00010;
    step(); step(); step();
    check_eq("t2_readback", last_rd[1], 8'h5A);

    // round robin among display ports
    pulse_reset();
    auto_mask = 4'b1110; req = 4'b1110;
    for (int i = 0; i < 6; i++) step();
    for (int i = 0; i < 6; i++) check_eq($sformatf("t3_rr%0d", i), log_q[i], exp_rr[i]);
    req = '0; auto_mask = '0;
    step(); step(); step();

    // starvation pre-emption of the CPU
    pulse_reset();
    auto_mask = 4'b1111; req = 4'b1111; cpu_we = 1'b0;
    for (int i = 0; i < 40; i++) step();
    for (int i = 0; i < 8; i++) check_eq($sformatf("t4_st%0d", i), log_q[i], exp_st[i]);
    check_eq("t4_max_wait_le6", 32'(maxw <= 6), 1);
    req = '0; auto_mask = '0;
    step(); step(); step();

    // reset mid-read discards the in-flight read
    pulse_reset();
    req = 4'b1000; a[3] = 17'h00777;
    step();
    check_eq("t5_ack3", last_ack, 4'b1000);
    rst = 1'b1;
    step(); check_eq("t5_rdv_a", rd_valid, 0);
    step(); check_eq("t5_rdv_b", rd_valid, 0);
    rst = 1'b0;
    req = 4'b1010; a[1] = 17'h00123;
    step();
    check_eq("t5_first_after_reset", last_ack, 4'b0010);
    check_eq("t5_rdv_c", rd_valid, 0);
    step(); step(); step();

    // withdrawn request never becomes urgent
    pulse_reset();
    auto_mask = 4'b0001; req = 4'b0011; a[1] = 17'h00040;
    step(); step();
    req[1] = 1'b0;
    for (int i = 0; i < 6; i++) step();
    begin
      logic [3:0] any_ack;
      any_ack = '0;
      foreach (log_q[i]) any_ack = any_ack | log_q[i];
      check_eq("t6_no_ack1", any_ack[1], 0);
    end
    log_q.delete();
    req[1] = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check_eq("t6_cpu_first", log_q[3], 4'b0001);
    check_eq("t6_port1_fifth", log_q[4], 4'b0010);
    req = '0; auto_mask = '0;
    step(); step(); step();

    // random traffic with hold-until-ack discipline
    pulse_reset();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!req[i] && $urandom_range(0, 1) == 1) begin
          req[i] = 1'b1;
          a[i] = 17'($urandom_range(0, 63));
          if (i == 0) begin
            cpu_we = 1'($urandom_range(0, 1));
            cpu_wrdata = 8'($urandom);
          end
        end else if (i != 0 && req[i] && $urandom_range(0, 15) == 0) begin
          req[i] = 1'b0;
        end
      end
      step();
    end
    req = '0;
    for (int i = 0; i < 4; i++) step();
    check_eq("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
